// File: rtl/encoder_gen_if.sv
// Encoder generator control/observation bundle.
// master drives the period/enable controls and observes the waveform;
// slave is the generator side.
interface encoder_gen_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 load;
  logic [WIDTH-1:0]     period_in;
  logic                 encoder;
  logic [WIDTH-1:0]     active_period;
  logic                 cycle_start;
  logic [CNT_WIDTH-1:0] pulse_count;

  modport master (
    output enable,
    output load,
    output period_in,
    input  encoder,
    input  active_period,
    input  cycle_start,
    input  pulse_count
  );

  modport slave (
    input  enable,
    input  load,
    input  period_in,
    output encoder,
    output active_period,
    output cycle_start,
    output pulse_count
  );
endinterface

// File: rtl/encoder_gen.sv
// Emulated encoder waveform generator.
// Produces a square wave of programmable period P (high floor(P/2) cycles,
// low P-floor(P/2) cycles). Period changes and enable changes are applied
// only at period boundaries or while idle, so a started period always
// completes. pulse_count counts started periods, wrapping naturally.
module encoder_gen #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  encoder_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t               r_state;
  logic                 r_encoder;
  logic                 r_cycle_start;
  logic [WIDTH-1:0]     r_active;
  logic [WIDTH-1:0]     r_pending;
  logic                 r_pend_valid;
  logic [CNT_WIDTH-1:0] r_pulse_count;
  logic [WIDTH-1:0]     r_count;

  logic [WIDTH-1:0]     w_cand;
  logic                 w_cand_ok;
  logic [WIDTH-1:0]     w_cand_high_m1;
  logic [WIDTH-1:0]     w_act_low_m1;
  logic                 w_boundary;
  logic                 w_start;

  // Candidate period for the next start: a same-cycle load beats the
  // pending register, which beats repeating the active period.
  always_comb begin
    w_cand = r_active;
    if (bus.load) begin
      w_cand = bus.period_in;
    end else if (r_pend_valid) begin
      w_cand = r_pending;
    end
  end

  // P >= 2 means some bit above bit 0 is set.
  assign w_cand_ok      = |w_cand[WIDTH-1:1];
  // High phase is floor(P/2); counter holds remaining cycles minus one.
  assign w_cand_high_m1 = (w_cand >> 1) - WIDTH'(1);
  // Low phase is P - floor(P/2), taken from the period being generated.
  assign w_act_low_m1   = r_active - (r_active >> 1) - WIDTH'(1);

  assign w_boundary = (r_state == LOW) && (r_count == '0);
  assign w_start    = bus.enable && w_cand_ok &&
                      ((r_state == IDLE) || w_boundary);

  // Phase sequencer, period/pending bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_encoder     <= 1'b0;
      r_cycle_start <= 1'b0;
      r_active      <= '0;
      r_pending     <= '0;
      r_pend_valid  <= 1'b0;
      r_pulse_count <= '0;
      r_count       <= '0;
    end else begin
      r_cycle_start <= 1'b0;

      if (bus.load) begin
        r_pending    <= bus.period_in;
        r_pend_valid <= 1'b1;
      end

      // A start consumes the candidate; clearing pend_valid here also
      // overrides a same-cycle load so the loaded value is not reused.
      if (w_start) begin
        r_state       <= HIGH;
        r_active      <= w_cand;
        r_encoder     <= 1'b1;
        r_count       <= w_cand_high_m1;
        r_cycle_start <= 1'b1;
        r_pulse_count <= r_pulse_count + CNT_WIDTH'(1);
        r_pend_valid  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_encoder <= 1'b0;
          end
          HIGH: begin
            if (r_count == '0) begin
              r_state   <= LOW;
              r_encoder <= 1'b0;
              r_count   <= w_act_low_m1;
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end
          LOW: begin
            if (r_count == '0) begin
              r_state   <= IDLE;
              r_encoder <= 1'b0;
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end
          default: begin
            r_state   <= IDLE;
            r_encoder <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.encoder       = r_encoder;
  assign bus.cycle_start   = r_cycle_start;
  assign bus.active_period = r_active;
  assign bus.pulse_count   = r_pulse_count;

endmodule

// File: doc/encoder_gen.md
ENCODER_GEN -- requirements
Module: encoder_gen

Interface
REQ-001 Parameter WIDTH, default 32, bit width of period values.
REQ-002 Parameter CNT_WIDTH, default 16, bit width of the pulse counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level; 1 = generate pulse train, 0 = stop at the next period boundary.
REQ-006 load  input  1  one-cycle strobe; captures period_in into the pending register.
REQ-007 period_in  input  WIDTH  requested period P in clk cycles (rising edge to rising edge).
REQ-008 encoder  output  1  registered emulated encoder waveform.
REQ-009 active_period  output  WIDTH  period currently being generated.
REQ-010 cycle_start  output  1  registered one-cycle pulse, high in the first high cycle of each period.
REQ-011 pulse_count  output  CNT_WIDTH  number of periods started; wraps modulo 2^CNT_WIDTH.

Function
REQ-012 Phase split SHALL be: high phase H = floor(P/2) cycles, low phase L = P - H cycles.
- P=2: 1/1; P=3: 1/2; P=5: 2/3.
REQ-013 Valid period SHALL be P >= 2; the block SHALL never start a period with P < 2.
REQ-014 Pending register: on load, pending <= period_in and pending_valid <= 1; the last load before a boundary wins.
REQ-015 Candidate period at a decision point SHALL be, in priority order:
- period_in, if load is high that cycle;
- else pending, if pending_valid;
- else active_period.
REQ-016 The FSM SHALL have exactly three states: IDLE, HIGH, LOW; a down-counter holds the cycles remaining in the current phase.
REQ-017 IDLE, with enable=1 and a valid candidate, SHALL on the next edge:
- set active_period <= candidate, state <= HIGH, encoder <= 1, counter <= H-1;
- pulse cycle_start <= 1 and increment pulse_count;
- clear pending_valid.
Otherwise it SHALL remain in IDLE with encoder=0.
REQ-018 HIGH SHALL decrement the counter; at counter==0 it SHALL go to LOW with encoder <= 0 and counter <= L-1.
REQ-019 LOW SHALL decrement the counter; at counter==0 (period boundary):
- enable=0: go to IDLE, encoder stays 0;
- enable=1 and valid candidate: act as REQ-017 with no gap cycle;
- enable=1 and invalid candidate: go to IDLE, active_period unchanged, pending retained.
REQ-020 A period in progress SHALL always complete; load and enable changes take effect only at a boundary or in IDLE.
REQ-021 cycle_start SHALL be 0 in every cycle except those given in REQ-017/019.
REQ-022 pulse_count SHALL wrap from 2^CNT_WIDTH-1 to 0 without any other side effect.
REQ-023 A load in the same cycle as a boundary SHALL apply the loaded value immediately and leave pending_valid=0 afterwards.
REQ-024 Counter arithmetic SHALL be WIDTH bits wide, so P = 2^WIDTH-1 is generated exactly.

Reset
REQ-025 Asserting reset SHALL immediately, asynchronously force:
- state=IDLE, encoder=0, cycle_start=0;
- active_period=0, pending=0, pending_valid=0, pulse_count=0, counter=0.
This applies in any state, including mid-period.
REQ-026 After reset deassertion, the first period SHALL start only via REQ-017.

Verification
REQ-027 Start, P=3: load P=3 with enable=1 -> encoder repeats 1,0,0; cycle_start every 3rd cycle; pulse_count 1,2,3...
REQ-028 Period change: running at P=3, load 5 during the high phase -> current period finishes as 1,0,0; next period is 1,1,0,0,0; active_period=5 from that period's first cycle.
REQ-029 Invalid period: from reset, load 1 with enable=1 -> encoder stays 0, pulse_count=0; then load 4 -> next edge encoder=1, pattern 1,1,0,0.
REQ-030 Stop: P=4, drop enable during the first high cycle -> the waveform completes 1,1,0,0, then IDLE with encoder=0 and no further cycle_start.
REQ-031 Reset mid-period: P=200 running, assert reset at cycle 50 of the high phase -> encoder=0 and pulse_count=0 without waiting for a clk edge.
REQ-032 Wrap: CNT_WIDTH=4, P=2, 17 periods -> pulse_count reads 15 then 0 then 1.
